// File: rtl/accel_pkg.sv
// Shared definitions for the accelerometer axis scheduler.
//   - axis encodings driven on the SPI reader's dimension input
//   - host command byte values from the parallel link
//   - scheduler and host-port state encodings
//   - small decode helpers for axis stepping and command decoding
package accel_pkg;

  localparam logic [1:0] AX_X = 2'd0;
  localparam logic [1:0] AX_Y = 2'd1;
  localparam logic [1:0] AX_Z = 2'd2;

  localparam logic [7:0] CMD_X_LO   = 8'd120;  // 'x'
  localparam logic [7:0] CMD_Y_LO   = 8'd121;  // 'y'
  localparam logic [7:0] CMD_Z_LO   = 8'd122;  // 'z'
  localparam logic [7:0] CMD_X_HI   = 8'd88;   // 'X'
  localparam logic [7:0] CMD_Y_HI   = 8'd89;   // 'Y'
  localparam logic [7:0] CMD_Z_HI   = 8'd90;   // 'Z'
  localparam logic [7:0] CMD_STATUS = 8'd115;  // 's'
  localparam logic [7:0] CMD_CLEAR  = 8'd99;   // 'c'

  typedef enum logic {
    SCH_SETTLE  = 1'b0,
    SCH_CAPTURE = 1'b1
  } sched_state_e;

  typedef enum logic [1:0] {
    HOST_IDLE    = 2'd0,
    HOST_SEND_LO = 2'd1,
    HOST_SEND_HI = 2'd2
  } host_state_e;

  // Round-robin X -> Y -> Z -> X; the unused code 3 also maps back to X.
  function automatic logic [1:0] next_axis(input logic [1:0] ax);
    logic [1:0] n;
    case (ax)
      AX_X:    n = AX_Y;
      AX_Y:    n = AX_Z;
      default: n = AX_X;
    endcase
    return n;
  endfunction

  function automatic logic is_axis_cmd(input logic [7:0] b);
    return (b == CMD_X_LO) || (b == CMD_Y_LO) || (b == CMD_Z_LO) ||
           (b == CMD_X_HI) || (b == CMD_Y_HI) || (b == CMD_Z_HI);
  endfunction

  // Non-axis bytes decode to X; callers qualify with is_axis_cmd.
  function automatic logic [1:0] cmd_axis(input logic [7:0] b);
    logic [1:0] a;
    case (b)
      CMD_Y_LO, CMD_Y_HI: a = AX_Y;
      CMD_Z_LO, CMD_Z_HI: a = AX_Z;
      default:            a = AX_X;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/accel_host_port.sv
// Host command port: decodes command bytes from the parallel link and
// returns sample bytes or a status byte.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   cmd_valid     one-cycle pulse, cmd_byte holds a host command
//   cmd_byte      host command byte
//   rsp_ack       host consumed rsp_byte
//   bank_rdata    sample bank entry selected by bank_idx
//   timeout_err   sticky watchdog flag (for the status byte)
//   fresh         per-axis new-data flags (for the status byte)
//   bank_idx      axis decoded from cmd_byte, selects bank_rdata
//   fresh_clr     strobe: clear fresh[bank_idx] this cycle
//   timeout_clr   strobe: clear timeout_err this cycle
//   rsp_byte      response byte
//   rsp_valid     response byte valid
//   state_dbg     current host state
//
// Handshake: rsp_byte is presented with rsp_valid high and held stable
// until a clock edge where rsp_valid and rsp_ack are both high; that edge
// retires the byte. rsp_ack with rsp_valid low has no effect. Commands are
// only accepted in IDLE; a cmd_valid pulse in any other state is dropped.
module accel_host_port
  import accel_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_byte,
  input  logic        rsp_ack,
  input  logic [15:0] bank_rdata,
  input  logic        timeout_err,
  input  logic [2:0]  fresh,
  output logic [1:0]  bank_idx,
  output logic        fresh_clr,
  output logic        timeout_clr,
  output logic [7:0]  rsp_byte,
  output logic        rsp_valid,
  output host_state_e state_dbg
);

  host_state_e state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  rsp_byte_q, rsp_byte_d;
  logic        rsp_valid_q, rsp_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HOST_IDLE;
      hold_q      <= '0;
      rsp_byte_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      rsp_byte_q  <= rsp_byte_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOST_IDLE: begin
        if (cmd_valid) begin
          if (is_axis_cmd(cmd_byte))       state_d = HOST_SEND_LO;
          else if (cmd_byte == CMD_STATUS) state_d = HOST_SEND_HI;
        end
      end
      HOST_SEND_LO: if (rsp_ack) state_d = HOST_SEND_HI;
      HOST_SEND_HI: if (rsp_ack) state_d = HOST_IDLE;
      default:      state_d = HOST_IDLE;
    endcase
  end

  // The whole sample is latched into hold_q when the command is taken, so
  // later bank writes cannot tear the low/high pair.
  always_comb begin
    hold_d      = hold_q;
    rsp_byte_d  = rsp_byte_q;
    rsp_valid_d = rsp_valid_q;
    fresh_clr   = 1'b0;
    timeout_clr = 1'b0;
    bank_idx    = cmd_axis(cmd_byte);
    case (state_q)
      HOST_IDLE: begin
        if (cmd_valid) begin
          if (is_axis_cmd(cmd_byte)) begin
            hold_d      = bank_rdata;
            rsp_byte_d  = bank_rdata[7:0];
            rsp_valid_d = 1'b1;
            fresh_clr   = 1'b1;
          end else if (cmd_byte == CMD_STATUS) begin
            rsp_byte_d  = {4'b0000, timeout_err, fresh};
            rsp_valid_d = 1'b1;
          end else if (cmd_byte == CMD_CLEAR) begin
            timeout_clr = 1'b1;
          end
        end
      end
      HOST_SEND_LO: if (rsp_ack) rsp_byte_d = hold_q[15:8];
      HOST_SEND_HI: if (rsp_ack) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign rsp_byte  = rsp_byte_q;
  assign rsp_valid = rsp_valid_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/accel_axis_scheduler.sv
// Accelerometer axis scheduler: steps the SPI reader through X, Y, Z,
// drops settling samples after each axis change, keeps the latest sample
// per axis and serves host requests for those samples.
//
// Ports:
//   CLK_50       50 MHz system clock
//   dly_rst      synchronous active-high reset
//   sample_stb   one-cycle pulse, sample_data holds a new SPI sample
//   sample_data  {high byte, low byte} from the SPI reader
//   dimension    axis driven to the SPI reader (0=X, 1=Y, 2=Z)
//   cmd_valid    one-cycle pulse, cmd_byte holds a host command
//   cmd_byte     host command byte
//   rsp_byte     response byte
//   rsp_valid    response byte valid, held until rsp_ack
//   rsp_ack      host consumed rsp_byte
//   fresh        per-axis new-data flags, bit n = axis n
//   timeout_err  sticky, set on any watchdog-forced axis advance
//
// Handshake: a response byte is transferred on an edge where rsp_valid
// and rsp_ack are both high; rsp_byte is stable while rsp_valid waits.
module accel_axis_scheduler
  import accel_pkg::*;
#(
  parameter int DISCARD = 1,
  parameter int KEEP    = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic        CLK_50,
  input  logic        dly_rst,
  input  logic        sample_stb,
  input  logic [15:0] sample_data,
  output logic [1:0]  dimension,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_byte,
  output logic [7:0]  rsp_byte,
  output logic        rsp_valid,
  input  logic        rsp_ack,
  output logic [2:0]  fresh,
  output logic        timeout_err
);

  localparam int DCW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
  localparam int KCW = (KEEP > 1) ? $clog2(KEEP + 1) : 1;
  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [DCW-1:0] DISC_INIT = DCW'(DISCARD);
  localparam logic [KCW-1:0] KEEP_MAX  = KCW'(KEEP);
  localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);

  sched_state_e     sched_q, sched_d;
  logic [DCW-1:0]   disc_q, disc_d;
  logic [KCW-1:0]   keep_q, keep_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [1:0]       dimension_q, dimension_d;
  logic [2:0]       fresh_q, fresh_d;
  logic             timeout_err_q, timeout_err_d;
  logic [2:0][15:0] bank_q, bank_d;

  logic        capture_wr;
  logic        keep_done;
  logic        settle_done;
  logic        wd_fire;
  logic        advance;

  logic [1:0]  host_idx;
  logic        host_fresh_clr;
  logic        host_timeout_clr;
  host_state_e host_state;

  always_ff @(posedge CLK_50) begin
    if (dly_rst) begin
      sched_q       <= SCH_SETTLE;
      disc_q        <= DISC_INIT;
      keep_q        <= '0;
      wd_q          <= '0;
      dimension_q   <= AX_X;
      fresh_q       <= '0;
      timeout_err_q <= 1'b0;
      bank_q        <= '0;
    end else begin
      sched_q       <= sched_d;
      disc_q        <= disc_d;
      keep_q        <= keep_d;
      wd_q          <= wd_d;
      dimension_q   <= dimension_d;
      fresh_q       <= fresh_d;
      timeout_err_q <= timeout_err_d;
      bank_q        <= bank_d;
    end
  end

  // Scheduler next state. SETTLE leaves on the strobe that uses up the
  // last discard, so the very next strobe is captured; with nothing to
  // discard it falls through after one cycle. Any advance (keep quota met
  // or watchdog) lands in SETTLE for the new axis.
  always_comb begin
    capture_wr  = (sched_q == SCH_CAPTURE) && sample_stb;
    keep_done   = capture_wr && ((keep_q + KCW'(1)) == KEEP_MAX);
    settle_done = (sched_q == SCH_SETTLE) &&
                  ((disc_q == '0) || (sample_stb && (disc_q == DCW'(1))));
    // A strobe in the same cycle restarts the watchdog instead of firing it.
    wd_fire     = !sample_stb && (wd_q == WD_LAST);
    advance     = keep_done || wd_fire;

    sched_d = sched_q;
    if (advance)          sched_d = SCH_SETTLE;
    else if (settle_done) sched_d = SCH_CAPTURE;
  end

  // Counters, bank and flags. Where a fresh bit is both cleared by a host
  // read and set by a capture in the same cycle, the set is applied last.
  always_comb begin
    dimension_d = advance ? next_axis(dimension_q) : dimension_q;

    disc_d = disc_q;
    if (advance)
      disc_d = DISC_INIT;
    else if ((sched_q == SCH_SETTLE) && sample_stb && (disc_q != '0))
      disc_d = disc_q - DCW'(1);

    keep_d = keep_q;
    if (advance || settle_done) keep_d = '0;
    else if (capture_wr)        keep_d = keep_q + KCW'(1);

    wd_d = (sample_stb || advance) ? '0 : wd_q + WDW'(1);

    bank_d = bank_q;
    if (capture_wr) bank_d[dimension_q] = sample_data;

    fresh_d = fresh_q;
    if (host_fresh_clr) fresh_d[host_idx]    = 1'b0;
    if (capture_wr)     fresh_d[dimension_q] = 1'b1;

    timeout_err_d = timeout_err_q;
    if (host_timeout_clr) timeout_err_d = 1'b0;
    if (wd_fire)          timeout_err_d = 1'b1;
  end

  // The host reads bank_q (registered), so a same-cycle capture to the
  // same axis is seen by the host only on a later request.
  accel_host_port u_host (
    .clk         (CLK_50),
    .rst         (dly_rst),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .rsp_ack     (rsp_ack),
    .bank_rdata  (bank_q[host_idx]),
    .timeout_err (timeout_err_q),
    .fresh       (fresh_q),
    .bank_idx    (host_idx),
    .fresh_clr   (host_fresh_clr),
    .timeout_clr (host_timeout_clr),
    .rsp_byte    (rsp_byte),
    .rsp_valid   (rsp_valid),
    .state_dbg   (host_state)
  );

  assign dimension   = dimension_q;
  assign fresh       = fresh_q;
  assign timeout_err = timeout_err_q;

endmodule
